// File: rtl/m2_write_back_pkg.sv
// Shared types and constants for the M2 write-back block: FSM states, segment
// encoding, Y/U/V segment bases and strides, and the pixel clip helper.
package m2_pkg;

    typedef enum logic [1:0] {
        S_WB_IDLE = 2'd0,
        S_WB_EVEN = 2'd1,
        S_WB_ODD  = 2'd2,
        S_WB_DONE = 2'd3
    } wb_state_t;

    typedef enum logic [1:0] {
        SEG_Y    = 2'd0,
        SEG_U    = 2'd1,
        SEG_V    = 2'd2,
        SEG_RSVD = 2'd3
    } wb_seg_t;

    localparam logic [17:0] Y_BASE_DEF = 18'd0;
    localparam logic [17:0] U_BASE_DEF = 18'd38400;
    localparam logic [17:0] V_BASE_DEF = 18'd57600;
    localparam logic [17:0] Y_STRIDE   = 18'd160;
    localparam logic [17:0] UV_STRIDE  = 18'd80;

    function automatic logic [7:0] clip_px(input logic signed [31:0] px);
        if (px < 32'sd0)
            return 8'd0;
        else if (px > 32'sd255)
            return 8'hFF;
        else
            return px[7:0];
    endfunction

endpackage

// File: rtl/m2_write_back_if.sv
// Pixel stream and SRAM write port of the write-back block.
// master = upstream IDCT/arbiter side, slave = the write-back block.
interface m2_write_back_if;
    logic signed [31:0] Pixel_in;
    logic               Pixel_valid;
    logic               Pixel_ready;
    logic               SRAM_grant;
    logic [17:0]        SRAM_address;
    logic [15:0]        SRAM_write_data;
    logic               SRAM_we_n;

    modport master (
        output Pixel_in, Pixel_valid, SRAM_grant,
        input  Pixel_ready, SRAM_address, SRAM_write_data, SRAM_we_n
    );

    modport slave (
        input  Pixel_in, Pixel_valid, SRAM_grant,
        output Pixel_ready, SRAM_address, SRAM_write_data, SRAM_we_n
    );
endinterface

// File: rtl/m2_write_back_addr_gen.sv
// Combinational SRAM word address for pixel pair (r, c) of the latched block.
// Segment 3 falls through to the V segment.
module m2_wb_addr_gen
    import m2_pkg::*;
#(
    parameter logic [17:0] Y_BASE = Y_BASE_DEF,
    parameter logic [17:0] U_BASE = U_BASE_DEF,
    parameter logic [17:0] V_BASE = V_BASE_DEF
) (
    input  wb_seg_t     seg,
    input  logic [4:0]  block_row,
    input  logic [5:0]  block_col,
    input  logic [2:0]  r,
    input  logic [2:0]  c,
    output logic [17:0] addr
);

    logic [17:0] base;
    logic [17:0] stride;

    always_comb begin
        base   = V_BASE;
        stride = UV_STRIDE;
        case (seg)
            SEG_Y: begin base = Y_BASE; stride = Y_STRIDE; end
            SEG_U: begin base = U_BASE; stride = UV_STRIDE; end
            default: begin base = V_BASE; stride = UV_STRIDE; end
        endcase
    end

    // {row, r} is row*8 + r and {col, 00} is col*4
    assign addr = base + 18'({block_row, r}) * stride
                + 18'({block_col, 2'b00}) + 18'(c >> 1);

endmodule

// File: rtl/m2_write_back.sv
// Packs clipped IDCT pixels into byte pairs and writes one 8x8 block to SRAM.
// Build option: define M2_WB_CLIP_EN to saturate pixels to 0..255 instead of truncating.
//
// state      | meaning
// S_WB_IDLE  | waiting for Start, pixel input ignored
// S_WB_EVEN  | next accepted pixel is the high (even) byte
// S_WB_ODD   | next accepted pixel completes a word into pending
// S_WB_DONE  | 32 words written, Block_done pulse
module m2_write_back
    import m2_pkg::*;
#(
    parameter logic [17:0] Y_BASE = Y_BASE_DEF,
    parameter logic [17:0] U_BASE = U_BASE_DEF,
    parameter logic [17:0] V_BASE = V_BASE_DEF
) (
    input  logic           Clock_50,
    input  logic           Reset,
    input  logic           Start,
    input  logic [1:0]     Segment,
    input  logic [4:0]     Block_row,
    input  logic [5:0]     Block_col,
    m2_write_back_if.slave wb,
    output logic           Block_done,
    output logic           Busy
);

    wb_state_t   state;
    wb_seg_t     seg_q;
    logic [4:0]  row_q;
    logic [5:0]  col_q;
    logic [7:0]  even_q;
    logic        pend_q;
    logic [15:0] pend_data;
    logic [4:0]  wr_idx;
    logic [5:0]  words_in;
    logic [7:0]  px_byte;
    logic        ready;
    logic        accept;
    logic        write_now;

`ifdef M2_WB_CLIP_EN
    assign px_byte = clip_px(wb.Pixel_in);
`else
    assign px_byte = wb.Pixel_in[7:0];
`endif

    assign write_now = pend_q & wb.SRAM_grant;

    // A stalled pending word blocks only the odd pixel; the even one can still be held.
    always_comb begin
        ready = 1'b0;
        case (state)
            S_WB_EVEN: ready = (words_in != 6'd32);
            S_WB_ODD:  ready = !pend_q || wb.SRAM_grant;
            default:   ready = 1'b0;
        endcase
    end

    assign accept             = wb.Pixel_valid & ready;
    assign wb.Pixel_ready     = ready;
    assign wb.SRAM_we_n       = ~write_now;
    assign wb.SRAM_write_data = pend_data;

    m2_wb_addr_gen #(
        .Y_BASE (Y_BASE),
        .U_BASE (U_BASE),
        .V_BASE (V_BASE)
    ) u_addr_gen (
        .seg       (seg_q),
        .block_row (row_q),
        .block_col (col_q),
        .r         (wr_idx[4:2]),
        .c         ({wr_idx[1:0], 1'b0}),
        .addr      (wb.SRAM_address)
    );

    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            state      <= S_WB_IDLE;
            seg_q      <= SEG_Y;
            row_q      <= 5'd0;
            col_q      <= 6'd0;
            even_q     <= 8'd0;
            pend_q     <= 1'b0;
            pend_data  <= 16'd0;
            wr_idx     <= 5'd0;
            words_in   <= 6'd0;
            Block_done <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            Block_done <= 1'b0;
            if (write_now) begin
                pend_q <= 1'b0;
                wr_idx <= wr_idx + 5'd1;
            end
            case (state)
                S_WB_IDLE: begin
                    if (Start) begin
                        seg_q    <= wb_seg_t'(Segment);
                        row_q    <= Block_row;
                        col_q    <= Block_col;
                        wr_idx   <= 5'd0;
                        words_in <= 6'd0;
                        Busy     <= 1'b1;
                        state    <= S_WB_EVEN;
                    end
                end
                S_WB_EVEN: begin
                    if (accept) begin
                        even_q <= px_byte;
                        state  <= S_WB_ODD;
                    end
                    if (write_now && wr_idx == 5'd31 && words_in == 6'd32) begin
                        Block_done <= 1'b1;
                        state      <= S_WB_DONE;
                    end
                end
                S_WB_ODD: begin
                    if (accept) begin
                        pend_q    <= 1'b1;
                        pend_data <= {even_q, px_byte};
                        words_in  <= words_in + 6'd1;
                        state     <= S_WB_EVEN;
                    end
                end
                S_WB_DONE: begin
                    Busy  <= 1'b0;
                    state <= S_WB_IDLE;
                end
                default: state <= S_WB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m2_write_back.sv
// Bench for m2_write_back: directed and random blocks scored against an
// address/data model built from the block geometry and pixel byte rule.
module tb_m2_write_back;

    logic       Clock_50 = 1'b0;
    logic       Reset;
    logic       Start;
    logic [1:0] Segment;
    logic [4:0] Block_row;
    logic [5:0] Block_col;
    logic       Block_done;
    logic       Busy;

    m2_write_back_if wb();

    m2_write_back dut (
        .Clock_50   (Clock_50),
        .Reset      (Reset),
        .Start      (Start),
        .Segment    (Segment),
        .Block_row  (Block_row),
        .Block_col  (Block_col),
        .wb         (wb),
        .Block_done (Block_done),
        .Busy       (Busy)
    );

    always #5 Clock_50 = ~Clock_50;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks   = 0;
    int  failures = 0;
    int  wr_cnt   = 0;
    bit  done_seen = 1'b0;
    bit  prev_done = 1'b0;
    int  pxa[64];
    int  px_cycles;

    function automatic int byte_of(input int px);
`ifdef M2_WB_CLIP_EN
        if (px < 0) return 0;
        if (px > 255) return 255;
        return px;
`else
        return px & 255;
`endif
    endfunction

    function automatic int seg_base(input int seg);
        if (seg == 0) return 0;
        if (seg == 1) return 38400;
        return 57600;
    endfunction

    task automatic push_block(input int seg, input int row, input int col, input int px[64]);
        wr_t e;
        int  stride;
        stride = (seg == 0) ? 160 : 80;
        for (int r = 0; r < 8; r++) begin
            for (int cp = 0; cp < 4; cp++) begin
                e.addr = seg_base(seg) + (row * 8 + r) * stride + col * 4 + cp;
                e.data = byte_of(px[r * 8 + 2 * cp]) * 256 + byte_of(px[r * 8 + 2 * cp + 1]);
                exp_q.push_back(e);
            end
        end
    endtask

    // Write scoreboard and Block_done checks
    always @(negedge Clock_50) begin
        if (!Reset) begin
            if (wb.SRAM_we_n === 1'b0) begin
                wr_cnt++;
                checks++;
                assert (exp_q.size() > 0) else begin
                    failures++;
                    $error("FAIL unexpected_write addr=%0d data=%h", wb.SRAM_address, wb.SRAM_write_data);
                end
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    checks++;
                    assert (wb.SRAM_address === 18'(mon_e.addr)) else begin
                        failures++;
                        $error("FAIL wr_addr got=%0d exp=%0d", wb.SRAM_address, mon_e.addr);
                    end
                    checks++;
                    assert (wb.SRAM_write_data === 16'(mon_e.data)) else begin
                        failures++;
                        $error("FAIL wr_data addr=%0d got=%h exp=%h", mon_e.addr, wb.SRAM_write_data, 16'(mon_e.data));
                    end
                end
            end
            if (Block_done === 1'b1) begin
                checks++;
                assert (wr_cnt === 32) else begin
                    failures++;
                    $error("FAIL done_word_count got=%0d exp=32", wr_cnt);
                end
                checks++;
                assert (prev_done === 1'b0) else begin
                    failures++;
                    $error("FAIL done_pulse_width got=2+ exp=1");
                end
                done_seen = 1'b1;
            end
            prev_done = Block_done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic check_reset_outputs(input string tag);
        checks++;
        assert (wb.SRAM_we_n === 1'b1) else begin failures++; $error("FAIL %s_we_n got=%b exp=1", tag, wb.SRAM_we_n); end
        checks++;
        assert (wb.SRAM_address === 18'd0) else begin failures++; $error("FAIL %s_addr got=%0d exp=0", tag, wb.SRAM_address); end
        checks++;
        assert (wb.SRAM_write_data === 16'd0) else begin failures++; $error("FAIL %s_data got=%h exp=0", tag, wb.SRAM_write_data); end
        checks++;
        assert (wb.Pixel_ready === 1'b0) else begin failures++; $error("FAIL %s_ready got=%b exp=0", tag, wb.Pixel_ready); end
        checks++;
        assert (Block_done === 1'b0) else begin failures++; $error("FAIL %s_done got=%b exp=0", tag, Block_done); end
        checks++;
        assert (Busy === 1'b0) else begin failures++; $error("FAIL %s_busy got=%b exp=0", tag, Busy); end
    endtask

    function automatic logic grant_val(input int gmode, input int cyc);
        if (gmode == 0) return 1'b1;
        if (gmode == 1) return ($urandom_range(0, 3) != 0);
        return (cyc >= 10);
    endfunction

    // Called #1 after a rising edge with the block idle.
    task automatic start_block(input int seg, input int row, input int col);
        done_seen = 1'b0;
        wr_cnt    = 0;
        Start     = 1'b1;
        Segment   = 2'(seg);
        Block_row = 5'(row);
        Block_col = 6'(col);
        @(posedge Clock_50); #1;
        Start     = 1'b0;
        Segment   = 2'($urandom_range(0, 3));
        Block_row = 5'($urandom_range(0, 29));
        Block_col = 6'($urandom_range(0, 39));
        checks++;
        assert (Busy === 1'b1) else begin failures++; $error("FAIL busy_after_start got=%b exp=1", Busy); end
    endtask

    // gmode: 0 grant always, 1 random grant, 2 grant low for the first 10 cycles
    task automatic feed(input int px[64], input int nstop, input int gmode, input int vmode);
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        while (idx < nstop && cyc < 3000) begin
            wb.Pixel_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            wb.Pixel_in    = px[idx];
            wb.SRAM_grant  = grant_val(gmode, cyc);
            Start          = (cyc == 7);
            @(negedge Clock_50);
            if (gmode == 2 && cyc >= 3 && cyc <= 9) begin
                checks++;
                assert (wb.Pixel_ready === 1'b0) else begin
                    failures++;
                    $error("FAIL stall_ready cyc=%0d got=%b exp=0", cyc, wb.Pixel_ready);
                end
            end
            if (gmode == 2 && cyc <= 9) begin
                checks++;
                assert (wb.SRAM_we_n === 1'b1) else begin
                    failures++;
                    $error("FAIL stall_no_write cyc=%0d got=%b exp=1", cyc, wb.SRAM_we_n);
                end
            end
            if (wb.Pixel_valid && wb.Pixel_ready) idx++;
            @(posedge Clock_50); #1;
            cyc++;
        end
        wb.Pixel_valid = 1'b0;
        Start          = 1'b0;
        px_cycles      = cyc;
        checks++;
        assert (idx == nstop) else begin failures++; $error("FAIL pixel_timeout got=%0d exp=%0d", idx, nstop); end
        if (nstop == 64) begin
            while (!done_seen && cyc < 3000) begin
                wb.SRAM_grant = grant_val(gmode, cyc);
                @(posedge Clock_50); #1;
                cyc++;
            end
            checks++;
            assert (done_seen) else begin failures++; $error("FAIL done_timeout got=0 exp=1"); end
        end
    endtask

    task automatic run_block(input int seg, input int row, input int col, input int px[64],
                             input int gmode, input int vmode);
        push_block(seg, row, col, px);
        start_block(seg, row, col);
        feed(px, 64, gmode, vmode);
    endtask

    initial begin
        int seg;
        Reset          = 1'b1;
        Start          = 1'b0;
        Segment        = 2'd0;
        Block_row      = 5'd0;
        Block_col      = 6'd0;
        wb.Pixel_valid = 1'b0;
        wb.Pixel_in    = 32'sd0;
        wb.SRAM_grant  = 1'b0;
        repeat (3) @(posedge Clock_50);
        #1;
        check_reset_outputs("reset");
        Reset = 1'b0;
        @(posedge Clock_50); #1;

        // Pixel_valid in idle must not be accepted
        wb.Pixel_valid = 1'b1;
        wb.Pixel_in    = 32'sd77;
        wb.SRAM_grant  = 1'b1;
        @(negedge Clock_50);
        checks++;
        assert (wb.Pixel_ready === 1'b0) else begin failures++; $error("FAIL idle_ready got=%b exp=0", wb.Pixel_ready); end
        @(posedge Clock_50); #1;
        wb.Pixel_valid = 1'b0;

        // Y(0,0) ramp at full rate
        for (int i = 0; i < 64; i++) pxa[i] = i;
        run_block(0, 0, 0, pxa, 0, 0);
        checks++;
        assert (px_cycles == 64) else begin failures++; $error("FAIL throughput got=%0d exp=64", px_cycles); end

        // U(29,19) constant 128, back to back
        for (int i = 0; i < 64; i++) pxa[i] = 128;
        run_block(1, 29, 19, pxa, 0, 0);

        // Last Y block with random pixels and handshake
        for (int i = 0; i < 64; i++) pxa[i] = int'($urandom_range(0, 900)) - 300;
        run_block(0, 29, 39, pxa, 1, 1);

        // Last V block, -5/300 pairs, grant held low at the start
        for (int i = 0; i < 64; i++) pxa[i] = (i % 2 == 0) ? -5 : 300;
        run_block(2, 29, 19, pxa, 2, 0);

        // Segment 3 behaves as V
        for (int i = 0; i < 64; i++) pxa[i] = int'($urandom_range(0, 900)) - 300;
        run_block(3, 5, 7, pxa, 1, 1);

        // Reset after 20 pixels, then the same block from the start
        for (int i = 0; i < 64; i++) pxa[i] = int'($urandom_range(0, 255));
        push_block(0, 3, 4, pxa);
        start_block(0, 3, 4);
        feed(pxa, 20, 0, 0);
        Reset = 1'b1;
        #1;
        exp_q.delete();
        check_reset_outputs("midreset");
        @(posedge Clock_50); #1;
        Reset = 1'b0;
        @(posedge Clock_50); #1;
        for (int i = 0; i < 64; i++) pxa[i] = int'($urandom_range(0, 255));
        run_block(0, 3, 4, pxa, 0, 0);

        // Random blocks
        for (int b = 0; b < 20; b++) begin
            seg = int'($urandom_range(0, 3));
            for (int i = 0; i < 64; i++) pxa[i] = int'($urandom_range(0, 900)) - 300;
            run_block(seg, int'($urandom_range(0, 29)),
                      int'($urandom_range(0, (seg == 0) ? 39 : 19)),
                      pxa, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge Clock_50);
        #1;
        checks++;
        assert (exp_q.size() == 0) else begin failures++; $error("FAIL leftover_writes got=%0d exp=0", exp_q.size()); end
        checks++;
        assert (Busy === 1'b0) else begin failures++; $error("FAIL final_busy got=%b exp=0", Busy); end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
